cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_FU execution units. The CDB is the broadcast that reservation stations snoop for wakeup and the ROB uses for completion.
- Each FU port has a 1-entry holding buffer, so an FU can complete a result and move on without waiting for a grant.
- Buffered results are granted round-robin, one per cycle, into a registered CDB output.
- A branch mispredict flushes all buffered and in-flight results.

Parameters:
- NUM_FU, 4, number of requesting execution units (2..8).
- PREG_WIDTH, 7, physical register tag width.
- ROB_WIDTH, 4, ROB tag width.
- DATA_WIDTH, 32, result data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_fu_valid  input  NUM_FU  per-FU result valid.
- i_fu_prd  input  NUM_FU*PREG_WIDTH  per-FU destination preg; slice i belongs to FU i.
- i_fu_rob_tag  input  NUM_FU*ROB_WIDTH  per-FU ROB tag.
- i_fu_data  input  NUM_FU*DATA_WIDTH  per-FU result data.
- o_fu_ready  output  NUM_FU  per-FU accept; a result transfers when valid && ready.
- o_cdb_valid  output  1  CDB broadcast valid.
- o_cdb_prd  output  PREG_WIDTH  broadcast preg.
- o_cdb_rob_tag  output  ROB_WIDTH  broadcast ROB tag.
- o_cdb_data  output  DATA_WIDTH  broadcast data.
- o_cdb_fu_id  output  $clog2(NUM_FU)  index of the FU whose result is on the CDB.
- branch_mispredict  input  1  flush.

Behaviour:
- State:
  - Per FU: buf_valid[i], plus buffered prd, rob_tag and data.
  - rr_ptr ($clog2(NUM_FU) bits).
  - CDB output register (valid, prd, rob_tag, data, fu_id).
- Reset (reset_n low, asynchronous):
  - buf_valid all 0; rr_ptr=0.
  - o_cdb_valid=0; o_cdb_prd, o_cdb_rob_tag, o_cdb_data, o_cdb_fu_id all 0.
  - o_fu_ready follows the combinational rule below, so it evaluates to all 1 while in reset.
  - Reset mid-operation discards every buffered and broadcast result.
- Arbitration (combinational):
  - Scan buffers starting at index rr_ptr, wrapping modulo NUM_FU; the first buf_valid entry is granted (grant[k]=1).
  - No grant when every buffer is empty or branch_mispredict=1.
- Ready: o_fu_ready[i] = !branch_mispredict && (!buf_valid[i] || grant[i]).
  - Depends on the FU's own buffer state and the grant only, never on i_fu_valid.
- Sequential, rising edge, no flush:
  - On grant k:
    - CDB register loads buffer k's fields, o_cdb_valid=1, o_cdb_fu_id=k.
    - buf_valid[k] clears unless refilled in the same cycle.
    - rr_ptr = (k+1) mod NUM_FU.
  - No grant: o_cdb_valid=0; data fields hold their last values; rr_ptr unchanged.
  - FU i handshake (i_fu_valid[i] && o_fu_ready[i]): buffer i loads the inputs, buf_valid[i]=1.
  - Simultaneous drain and refill of the same buffer keeps buf_valid=1 with the new contents; no bubble.
- Latency:
  - An FU handshake at edge t is broadcast at edge t+1 at the earliest, so o_cdb_valid is high in cycle t+1 to t+2.
  - There is no bypass from FU input to the CDB.
- Throughput: 1 broadcast per cycle. Under continuous contention each FU is granted at least once every NUM_FU cycles (no starvation).
- prd==0 results (stores, branches) are arbitrated and broadcast like any other, because the ROB needs the completion. Preg-0 filtering belongs to the consumers.
- Flush (branch_mispredict=1 at an edge):
  - All buf_valid cleared; o_cdb_valid cleared; incoming FU results are not accepted (ready=0).
  - rr_ptr unchanged.
  - Flush takes precedence over every simultaneous grant and handshake.
- Not supported, no handling: more than one broadcast per cycle, and backpressure from the CDB.

Test Plan:
- Reset: drive reset_n=0 mid-traffic with buf_valid=4'b1011 -> immediately o_cdb_valid=0, buffers empty; after release o_fu_ready=4'b1111 and rr_ptr=0.
- Single result: FU2 valid prd=7'd9, rob=4'd3, data=32'hDEAD_BEEF at edge t -> at edge t+1 o_cdb_valid=1, prd=9, rob_tag=3, data=DEADBEEF, fu_id=2; at edge t+2 o_cdb_valid=0.
- Round-robin contention: all 4 FUs hold continuous valid from reset -> broadcast fu_id order 0,1,2,3,0,…; each FU's ready toggles high exactly on its grant cycle.
- Same-cycle drain and refill: FU1 buffered and granted while presenting a new result (rob=5) -> next broadcast from FU1 carries rob=5 without a gap in buf_valid[1]; the order of the other FUs is unaffected.
- Flush: buffers 0 and 3 full and CDB valid, assert branch_mispredict for one cycle with FU2 valid -> next cycle o_cdb_valid=0, all buffers empty, FU2 result not accepted; rr_ptr retained, so the next grant order resumes from it.
- prd=0 result: FU0 sends prd=0, rob=4'd7 -> broadcast with o_cdb_valid=1, prd=0, rob_tag=7.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU single-entry result buffers drained
// round-robin, one per cycle, into a registered CDB broadcast.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_FU-1:0]            i_fu_valid,
  input  logic [NUM_FU*PREG_WIDTH-1:0] i_fu_prd,
  input  logic [NUM_FU*ROB_WIDTH-1:0]  i_fu_rob_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0] i_fu_data,
  output logic [NUM_FU-1:0]            o_fu_ready,
  output logic                         o_cdb_valid,
  output logic [PREG_WIDTH-1:0]        o_cdb_prd,
  output logic [ROB_WIDTH-1:0]         o_cdb_rob_tag,
  output logic [DATA_WIDTH-1:0]        o_cdb_data,
  output logic [$clog2(NUM_FU)-1:0]    o_cdb_fu_id,
  input  logic                         branch_mispredict
);

  localparam int ID_WIDTH = $clog2(NUM_FU);

  logic [NUM_FU-1:0]     buf_valid;
  logic [PREG_WIDTH-1:0] buf_prd  [NUM_FU];
  logic [ROB_WIDTH-1:0]  buf_rob  [NUM_FU];
  logic [DATA_WIDTH-1:0] buf_data [NUM_FU];
  logic [ID_WIDTH-1:0]   rr_ptr;

  logic [NUM_FU-1:0]     grant;
  logic                  grant_any;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic [NUM_FU-1:0]     take;

  // Rotating priority scan starting at rr_ptr; a flush suppresses every grant.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      scan_idx = ID_WIDTH'((int'(rr_ptr) + j) % NUM_FU);
      if (!grant_any && buf_valid[scan_idx] && !branch_mispredict) begin
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
        grant_any       = 1'b1;
      end
    end
  end

  assign o_fu_ready = branch_mispredict ? '0 : (~buf_valid | grant);
  assign take       = i_fu_valid & o_fu_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid     <= '0;
      rr_ptr        <= '0;
      o_cdb_valid   <= 1'b0;
      o_cdb_prd     <= '0;
      o_cdb_rob_tag <= '0;
      o_cdb_data    <= '0;
      o_cdb_fu_id   <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_prd[i]  <= '0;
        buf_rob[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else if (branch_mispredict) begin
      buf_valid   <= '0;
      o_cdb_valid <= 1'b0;
    end else begin
      o_cdb_valid <= grant_any;
      if (grant_any) begin
        o_cdb_prd     <= buf_prd[grant_id];
        o_cdb_rob_tag <= buf_rob[grant_id];
        o_cdb_data    <= buf_data[grant_id];
        o_cdb_fu_id   <= grant_id;
        rr_ptr        <= ID_WIDTH'((int'(grant_id) + 1) % NUM_FU);
      end
      // A refill wins over the drain so a granted buffer can reload without a bubble.
      for (int i = 0; i < NUM_FU; i++) begin
        if (take[i]) begin
          buf_valid[i] <= 1'b1;
          buf_prd[i]   <= i_fu_prd[i*PREG_WIDTH +: PREG_WIDTH];
          buf_rob[i]   <= i_fu_rob_tag[i*ROB_WIDTH +: ROB_WIDTH];
          buf_data[i]  <= i_fu_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus a contention sequence.
module tb_cdb_arbiter;

  localparam int NUM_FU = 4;
  localparam int PW = 7;
  localparam int RW = 4;
  localparam int DW = 32;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_FU-1:0]    i_fu_valid;
  logic [NUM_FU*PW-1:0] i_fu_prd;
  logic [NUM_FU*RW-1:0] i_fu_rob_tag;
  logic [NUM_FU*DW-1:0] i_fu_data;
  logic [NUM_FU-1:0]    o_fu_ready;
  logic                 o_cdb_valid;
  logic [PW-1:0]        o_cdb_prd;
  logic [RW-1:0]        o_cdb_rob_tag;
  logic [DW-1:0]        o_cdb_data;
  logic [1:0]           o_cdb_fu_id;
  logic                 branch_mispredict;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_FU(NUM_FU), .PREG_WIDTH(PW), .ROB_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_fu_valid(i_fu_valid),
    .i_fu_prd(i_fu_prd),
    .i_fu_rob_tag(i_fu_rob_tag),
    .i_fu_data(i_fu_data),
    .o_fu_ready(o_fu_ready),
    .o_cdb_valid(o_cdb_valid),
    .o_cdb_prd(o_cdb_prd),
    .o_cdb_rob_tag(o_cdb_rob_tag),
    .o_cdb_data(o_cdb_data),
    .o_cdb_fu_id(o_cdb_fu_id),
    .branch_mispredict(branch_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every FU presents the same prd/rob; FU i presents data + i.
  typedef struct {
    logic        rst_n;
    logic        bm;
    logic [3:0]  v;
    logic [6:0]  prd;
    logic [3:0]  rob;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        cv;
    logic [1:0]  id;
    logic [6:0]  cprd;
    logic [3:0]  crob;
    logic [31:0] cdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_n, input logic bm, input logic [3:0] v,
                     input logic [6:0] prd, input logic [3:0] rob, input logic [31:0] data,
                     input logic [3:0] ready, input logic cv, input logic [1:0] id,
                     input logic [6:0] cprd, input logic [3:0] crob, input logic [31:0] cdata);
    vec_t t;
    t.rst_n = rst_n; t.bm = bm; t.v = v; t.prd = prd; t.rob = rob; t.data = data;
    t.ready = ready; t.cv = cv; t.id = id; t.cprd = cprd; t.crob = crob; t.cdata = cdata;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [6:0] prd, input logic [3:0] rob,
                       input logic [31:0] data, input logic bm);
    i_fu_valid = v;
    branch_mispredict = bm;
    for (int i = 0; i < NUM_FU; i++) begin
      i_fu_prd[i*PW +: PW]     = prd;
      i_fu_rob_tag[i*RW +: RW] = rob;
      i_fu_data[i*DW +: DW]    = data + 32'(i);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(4'b0, 7'd0, 4'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);

    // rst bm v prd rob data | ready cv id cprd crob cdata
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b0100, 7'd9, 4'd3, 32'hDEADBEED, 4'b1111, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 1,2'd2, 7'd9, 4'd3, 32'hDEADBEEF);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd2, 7'd9, 4'd3, 32'hDEADBEEF);
    add(1,0,4'b0001, 7'd0, 4'd7, 32'h10000000, 4'b1111, 0,2'd2, 7'd9, 4'd3, 32'hDEADBEEF);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd2, 7'd9, 4'd3, 32'hDEADBEEF);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 1,2'd0, 7'd0, 4'd7, 32'h10000000);
    add(1,0,4'b1011, 7'd1, 4'd1, 32'h100,      4'b1111, 0,2'd0, 7'd0, 4'd7, 32'h10000000);
    add(1,0,4'b0010, 7'd2, 4'd2, 32'h200,      4'b0110, 0,2'd0, 7'd0, 4'd7, 32'h10000000);
    add(0,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b1111, 7'd10,4'd0, 32'h0A00,     4'b1111, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b1111, 7'd11,4'd1, 32'h0B00,     4'b0001, 0,2'd0, 7'd0, 4'd0, 32'h0);
    add(1,0,4'b1111, 7'd12,4'd2, 32'h0C00,     4'b0010, 1,2'd0, 7'd10,4'd0, 32'h0A00);
    add(1,0,4'b1111, 7'd13,4'd5, 32'h0D00,     4'b0100, 1,2'd1, 7'd10,4'd0, 32'h0A01);
    add(1,0,4'b1111, 7'd14,4'd6, 32'h0E00,     4'b1000, 1,2'd2, 7'd10,4'd0, 32'h0A02);
    add(1,0,4'b1111, 7'd15,4'd7, 32'h0F00,     4'b0001, 1,2'd3, 7'd10,4'd0, 32'h0A03);
    add(1,0,4'b0010, 7'd16,4'd5, 32'h1000,     4'b0010, 1,2'd0, 7'd11,4'd1, 32'h0B00);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b0100, 1,2'd1, 7'd12,4'd2, 32'h0C01);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1100, 1,2'd2, 7'd13,4'd5, 32'h0D02);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1101, 1,2'd3, 7'd14,4'd6, 32'h0E03);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 1,2'd0, 7'd15,4'd7, 32'h0F00);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 1,2'd1, 7'd16,4'd5, 32'h1001);
    add(1,0,4'b0001, 7'd20,4'd8, 32'h2000,     4'b1111, 0,2'd1, 7'd16,4'd5, 32'h1001);
    add(1,0,4'b1011, 7'd21,4'd9, 32'h2100,     4'b1111, 0,2'd1, 7'd16,4'd5, 32'h1001);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b0110, 1,2'd0, 7'd20,4'd8, 32'h2000);
    add(1,1,4'b0100, 7'd22,4'd10,32'h2200,     4'b0000, 1,2'd1, 7'd21,4'd9, 32'h2101);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd1, 7'd21,4'd9, 32'h2101);
    add(1,0,4'b1010, 7'd23,4'd11,32'h2300,     4'b1111, 0,2'd1, 7'd21,4'd9, 32'h2101);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1101, 0,2'd1, 7'd21,4'd9, 32'h2101);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 1,2'd3, 7'd23,4'd11,32'h2303);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 1,2'd1, 7'd23,4'd11,32'h2301);
    add(1,0,4'b0000, 7'd0, 4'd0, 32'h0,        4'b1111, 0,2'd1, 7'd23,4'd11,32'h2301);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      reset_n = vq[k].rst_n;
      drive(vq[k].v, vq[k].prd, vq[k].rob, vq[k].data, vq[k].bm);
      #1;
      chk("ready",   k, 32'(o_fu_ready),    32'(vq[k].ready));
      chk("cdb_vld", k, 32'(o_cdb_valid),   32'(vq[k].cv));
      chk("fu_id",   k, 32'(o_cdb_fu_id),   32'(vq[k].id));
      chk("prd",     k, 32'(o_cdb_prd),     32'(vq[k].cprd));
      chk("rob_tag", k, 32'(o_cdb_rob_tag), 32'(vq[k].crob));
      chk("data",    k, o_cdb_data,         vq[k].cdata);
    end

    // Continuous contention from rr_ptr=2: broadcasts cycle 2,3,0,1,... after a 2-cycle fill latency.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(4'b1111, 7'(c), 4'(c), 32'h5000, 1'b0);
      #1;
      if (c < 2) begin
        chk("rr_cdb_vld", 100 + c, 32'(o_cdb_valid), 32'd0);
      end else begin
        chk("rr_cdb_vld", 100 + c, 32'(o_cdb_valid), 32'd1);
        chk("rr_fu_id",   100 + c, 32'(o_cdb_fu_id), 32'(c % 4));
      end
      if (c >= 1)
        chk("rr_ready", 100 + c, 32'(o_fu_ready), 32'(4'b0001 << ((c + 1) % 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
